// File: rtl/fc_layer_stream_pkg.sv
// Shared types and helpers for the streaming fully-connected layer core.
// Saturation works on a fixed 64-bit carrier, so accumulators must stay narrower than SAT_W.
package fc_pkg;

  typedef enum logic [1:0] {
    ACT_NONE  = 2'd0,
    ACT_RELU  = 2'd1,
    ACT_LEAKY = 2'd2
  } act_mode_e;

  typedef enum logic [1:0] {
    S_LOAD_X,
    S_MAC,
    S_FIN,
    S_OUT
  } fc_state_e;

  localparam int SAT_W = 64;

  function automatic int acc_width(input int t, input int n);
    return 2 * t + $clog2(n) + 1;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat(input logic signed [SAT_W-1:0] acc,
                                                  input int t);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (t - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (t - 1));
    if (acc > hi) return hi;
    if (acc < lo) return lo;
    return acc;
  endfunction

endpackage

// File: rtl/fc_layer_stream_if.sv
// Stream bundle for fc_layer_stream: x input, weight/bias load, y output, activation select.
interface fc_layer_stream_if #(
  parameter int T = 16
);
  logic                input_valid;
  logic                input_ready;
  logic signed [T-1:0] input_data;
  logic                w_valid;
  logic                w_ready;
  logic signed [T-1:0] w_data;
  logic [1:0]          act_mode;
  logic                output_valid;
  logic                output_ready;
  logic signed [T-1:0] output_data;

  modport master (
    output input_valid, input_data, w_valid, w_data, act_mode, output_ready,
    input  input_ready, w_ready, output_valid, output_data
  );

  modport slave (
    input  input_valid, input_data, w_valid, w_data, act_mode, output_ready,
    output input_ready, w_ready, output_valid, output_data
  );
endinterface

// File: rtl/fc_layer_stream_lane_mac.sv
// One MAC lane: weight/bias storage for outputs m with m%P == lane, accumulator,
// and the bias/activation/saturation stage feeding a registered result.
module fc_lane_mac import fc_pkg::*; #(
  parameter  int M  = 16,
  parameter  int N  = 8,
  parameter  int T  = 16,
  parameter  int P  = 8,
  localparam int G  = M / P,
  localparam int AW = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int GW = (G > 1) ? $clog2(G) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_we_i,
  input  logic [AW-1:0]       w_addr_i,
  input  logic                b_we_i,
  input  logic [GW-1:0]       b_addr_i,
  input  logic signed [T-1:0] wdata_i,
  input  logic [AW-1:0]       rd_addr_i,
  input  logic [GW-1:0]       grp_i,
  input  logic signed [T-1:0] x_i,
  input  logic                acc_clr_i,
  input  logic                acc_en_i,
  input  logic                fin_en_i,
  input  act_mode_e           mode_i,
  output logic signed [T-1:0] y_o
);

  localparam int ACC_W = acc_width(T, N);

  if (ACC_W >= SAT_W) begin : g_acc_too_wide
    $error("fc_lane_mac: accumulator width exceeds saturation carrier");
  end

  logic signed [T-1:0]     wmem [G*N];
  logic signed [T-1:0]     bmem [G];
  logic signed [T-1:0]     w_rd_q;
  logic signed [T-1:0]     b_rd_q;
  logic signed [2*T-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] biased;
  logic signed [ACC_W-1:0] act;
  logic signed [T-1:0]     y_d;
  logic signed [T-1:0]     y_q;

  // Coefficient storage is deliberately unreset so a loaded model survives reset.
  always_ff @(posedge clk) begin
    if (w_we_i) wmem[w_addr_i] <= wdata_i;
    if (b_we_i) bmem[b_addr_i] <= wdata_i;
    w_rd_q <= wmem[rd_addr_i];
    b_rd_q <= bmem[grp_i];
  end

  assign prod     = (2*T)'(w_rd_q) * (2*T)'(x_i);
  assign prod_ext = {{(ACC_W-2*T){prod[2*T-1]}}, prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (acc_clr_i) begin
      acc_q <= '0;
    end else if (acc_en_i) begin
      acc_q <= acc_q + prod_ext;
    end
  end

  always_comb begin
    biased = acc_q + {{(ACC_W-T){b_rd_q[T-1]}}, b_rd_q};
    act    = biased;
    case (mode_i)
      ACT_RELU:  if (biased < 0) act = '0;
      ACT_LEAKY: if (biased < 0) act = biased >>> 3;
      default:   act = biased;
    endcase
    y_d = T'(sat({{(SAT_W-ACC_W){act[ACC_W-1]}}, act}, T));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= '0;
    end else if (fin_en_i) begin
      y_q <= y_d;
    end
  end

  assign y_o = y_q;

endmodule

// File: rtl/fc_layer_stream.sv
// Weight-loadable FC layer: y = act(W.x + b), M outputs from N inputs over P lanes,
// evaluated as M/P serial groups; FSM, counters, weight steering and output mux live here.
module fc_layer_stream import fc_pkg::*; #(
  parameter  int M  = 16,
  parameter  int N  = 8,
  parameter  int T  = 16,
  parameter  int P  = 8,
  localparam int G  = M / P,
  localparam int AW = (G * N > 1) ? $clog2(G * N) : 1,
  localparam int GW = (G > 1) ? $clog2(G) : 1,
  localparam int XW = (N > 1) ? $clog2(N) : 1,
  localparam int NW = $clog2(N + 1),
  localparam int KW = (P > 1) ? $clog2(P) : 1
) (
  input logic               clk,
  input logic               reset,
  fc_layer_stream_if.slave  bus
);

  if (M % P != 0) begin : g_cfg_err
    $error("fc_layer_stream: M must be a multiple of P");
  end

  fc_state_e           state_q, state_d;
  logic                live_q;
  logic [XW-1:0]       xcnt_q, xcnt_d;
  logic [GW-1:0]       g_q, g_d;
  logic [KW-1:0]       k_q, k_d;
  logic [NW-1:0]       mcyc_q, mcyc_d;
  act_mode_e           mode_q, mode_d;
  logic signed [T-1:0] xbuf_q [N];
  logic signed [T-1:0] xbuf_d [N];
  logic signed [T-1:0] x_pipe_q, x_pipe_d;
  logic                acc_en_q, acc_en_d;
  logic [XW-1:0]       wn_q, wn_d;
  logic [KW-1:0]       wlane_q, wlane_d;
  logic [GW-1:0]       wgrp_q, wgrp_d;
  logic                wbias_q, wbias_d;

  logic                x_first, in_rdy, w_rdy, x_hs, w_hs, y_hs;
  logic                acc_clr, fin_en;
  logic [AW-1:0]       rd_addr, w_addr;
  logic signed [T-1:0] lane_y [P];

  assign x_first = (xcnt_q == '0);
  assign w_rdy   = live_q && (state_q == S_LOAD_X) && x_first;
  assign in_rdy  = live_q && (state_q == S_LOAD_X) && !(bus.w_valid && x_first);
  assign x_hs    = bus.input_valid && in_rdy;
  assign w_hs    = bus.w_valid && w_rdy;
  assign y_hs    = (state_q == S_OUT) && bus.output_ready;
  assign w_addr  = AW'(int'(wgrp_q) * N + int'(wn_q));

  assign bus.input_ready  = in_rdy;
  assign bus.w_ready      = w_rdy;
  assign bus.output_valid = (state_q == S_OUT);
  assign bus.output_data  = (state_q == S_OUT) ? lane_y[k_q] : '0;

  always_comb begin
    state_d  = state_q;
    xcnt_d   = xcnt_q;
    g_d      = g_q;
    k_d      = k_q;
    mcyc_d   = mcyc_q;
    mode_d   = mode_q;
    xbuf_d   = xbuf_q;
    x_pipe_d = '0;
    acc_en_d = 1'b0;
    wn_d     = wn_q;
    wlane_d  = wlane_q;
    wgrp_d   = wgrp_q;
    wbias_d  = wbias_q;
    acc_clr  = 1'b0;
    fin_en   = 1'b0;
    rd_addr  = '0;

    // The weight counter is kept as (row-in-group, lane, group) digits so the
    // lane/address of weight m*N+n falls out without dividing by N or P.
    if (w_hs) begin
      if (!wbias_q && int'(wn_q) != N - 1) begin
        wn_d = wn_q + XW'(1);
      end else begin
        wn_d = '0;
        if (int'(wlane_q) != P - 1) begin
          wlane_d = wlane_q + KW'(1);
        end else begin
          wlane_d = '0;
          if (int'(wgrp_q) != G - 1) begin
            wgrp_d = wgrp_q + GW'(1);
          end else begin
            wgrp_d  = '0;
            wbias_d = !wbias_q;
          end
        end
      end
    end

    case (state_q)
      S_LOAD_X: begin
        if (x_hs) begin
          xbuf_d[xcnt_q] = bus.input_data;
          if (x_first) begin
            case (bus.act_mode)
              2'd1:    mode_d = ACT_RELU;
              2'd2:    mode_d = ACT_LEAKY;
              default: mode_d = ACT_NONE;
            endcase
          end
          if (int'(xcnt_q) == N - 1) begin
            xcnt_d  = '0;
            g_d     = '0;
            mcyc_d  = '0;
            state_d = S_MAC;
          end else begin
            xcnt_d = xcnt_q + XW'(1);
          end
        end
      end
      S_MAC: begin
        acc_clr = (mcyc_q == '0);
        if (int'(mcyc_q) < N) begin
          rd_addr  = AW'(int'(g_q) * N + int'(mcyc_q));
          x_pipe_d = xbuf_q[XW'(mcyc_q)];
          acc_en_d = 1'b1;
          mcyc_d   = mcyc_q + NW'(1);
        end else begin
          mcyc_d  = '0;
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        fin_en  = 1'b1;
        k_d     = '0;
        state_d = S_OUT;
      end
      S_OUT: begin
        if (y_hs) begin
          if (int'(k_q) == P - 1) begin
            k_d = '0;
            if (int'(g_q) == G - 1) begin
              state_d = S_LOAD_X;
            end else begin
              g_d     = g_q + GW'(1);
              mcyc_d  = '0;
              state_d = S_MAC;
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      default: state_d = S_LOAD_X;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_LOAD_X;
      live_q   <= 1'b0;
      xcnt_q   <= '0;
      g_q      <= '0;
      k_q      <= '0;
      mcyc_q   <= '0;
      mode_q   <= ACT_NONE;
      xbuf_q   <= '{default: '0};
      x_pipe_q <= '0;
      acc_en_q <= 1'b0;
      wn_q     <= '0;
      wlane_q  <= '0;
      wgrp_q   <= '0;
      wbias_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      live_q   <= 1'b1;
      xcnt_q   <= xcnt_d;
      g_q      <= g_d;
      k_q      <= k_d;
      mcyc_q   <= mcyc_d;
      mode_q   <= mode_d;
      xbuf_q   <= xbuf_d;
      x_pipe_q <= x_pipe_d;
      acc_en_q <= acc_en_d;
      wn_q     <= wn_d;
      wlane_q  <= wlane_d;
      wgrp_q   <= wgrp_d;
      wbias_q  <= wbias_d;
    end
  end

  for (genvar i = 0; i < P; i++) begin : g_lane
    fc_lane_mac #(
      .M(M),
      .N(N),
      .T(T),
      .P(P)
    ) u_lane (
      .clk       (clk),
      .rst_n     (reset),
      .w_we_i    (w_hs && !wbias_q && (int'(wlane_q) == i)),
      .w_addr_i  (w_addr),
      .b_we_i    (w_hs && wbias_q && (int'(wlane_q) == i)),
      .b_addr_i  (wgrp_q),
      .wdata_i   (bus.w_data),
      .rd_addr_i (rd_addr),
      .grp_i     (g_q),
      .x_i       (x_pipe_q),
      .acc_clr_i (acc_clr),
      .acc_en_i  (acc_en_q),
      .fin_en_i  (fin_en),
      .mode_i    (mode_q),
      .y_o       (lane_y[i])
    );
  end

endmodule

// File: tb/tb_fc_layer_stream.sv
// Directed bench for fc_layer_stream (M=4, N=2, T=8, P=2) against an arithmetic reference model.
module tb_fc_layer_stream;

  localparam int M = 4;
  localparam int N = 2;
  localparam int T = 8;
  localparam int P = 2;
  localparam int NW_BEATS = M * N + M;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fc_layer_stream_if #(.T(T)) bus ();

  fc_layer_stream #(
    .M(M),
    .N(N),
    .T(T),
    .P(P)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int vec  = 0;
  int errs = 0;
  int Wm [M][N];
  int Bm [M];
  int wflat [NW_BEATS];
  int exp_q [$];

  task automatic check(input string name, input int got, input int req);
    vec++;
    if (got != req) begin
      errs++;
      $display("FAIL %s got=%0d required=%0d at %0t", name, got, req, $time);
    end
  endtask

  // Reference: plain signed arithmetic, floor-divide for leaky, clamp to T bits.
  function automatic int model_y(input int m, input int x0, input int x1, input int mode);
    int a;
    a = Bm[m] + Wm[m][0] * x0 + Wm[m][1] * x1;
    if (mode == 1 && a < 0) a = 0;
    if (mode == 2 && a < 0) a = -((-a + 7) / 8);
    if (a > 127) a = 127;
    if (a < -128) a = -128;
    return a;
  endfunction

  task automatic build_w();
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) wflat[m*N+n] = Wm[m][n];
      wflat[M*N+m] = Bm[m];
    end
  endtask

  task automatic set_all(input int wv, input int bv);
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) Wm[m][n] = wv;
      Bm[m] = bv;
    end
    build_w();
  endtask

  task automatic load_w(input int first);
    for (int i = first; i < NW_BEATS; i++) begin
      bit ok;
      ok = 1'b0;
      bus.w_valid = 1'b1;
      bus.w_data  = 8'(wflat[i]);
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        if (bus.w_ready) begin
          ok = 1'b1;
          @(posedge clk);
          #1;
        end
      end
      if (!ok) check("w_accept_timeout", 0, 1);
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic send_x(input int x0, input int x1, input int mode);
    int xv [2];
    xv[0] = x0;
    xv[1] = x1;
    for (int n = 0; n < N; n++) begin
      bit ok;
      ok = 1'b0;
      bus.input_valid = 1'b1;
      bus.input_data  = 8'(xv[n]);
      bus.act_mode    = 2'(mode);
      for (int t = 0; t < 200 && !ok; t++) begin
        @(negedge clk);
        if (bus.input_ready) begin
          if (n > 0) check("w_ready_mid_vector", int'(bus.w_ready), 0);
          ok = 1'b1;
          @(posedge clk);
          #1;
        end
      end
      if (!ok) check("x_accept_timeout", 0, 1);
    end
    bus.input_valid = 1'b0;
    for (int m = 0; m < M; m++) exp_q.push_back(model_y(m, x0, x1, mode));
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Compare process: every valid output beat against the model queue.
  always @(negedge clk) begin
    if (rst_n && bus.output_valid) begin
      if (exp_q.size() == 0) begin
        vec++;
        errs++;
        $display("FAIL y_unexpected got=%0d required=no beat at %0t", int'(bus.output_data), $time);
      end else begin
        check("y_data", int'(bus.output_data), exp_q[0]);
        if (bus.output_ready) void'(exp_q.pop_front());
      end
      check("ready_low_in_out", int'({bus.input_ready, bus.w_ready}), 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int d0;
    bit seen;
    bit ok;
    bus.input_valid  = 1'b0;
    bus.input_data   = '0;
    bus.w_valid      = 1'b0;
    bus.w_data       = '0;
    bus.act_mode     = 2'd0;
    bus.output_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_output_valid", int'(bus.output_valid), 0);
    check("rst_output_data", int'(bus.output_data), 0);
    check("rst_input_ready", int'(bus.input_ready), 0);
    check("rst_w_ready", int'(bus.w_ready), 0);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 4 && !ok; t++) begin
      @(negedge clk);
      if (bus.input_ready) ok = 1'b1;
    end
    check("ready_after_reset", int'(ok), 1);
    check("w_ready_after_reset", int'(bus.w_ready), 1);
    @(posedge clk);
    #1;

    // All-ones weights, zero bias, plus first-output latency.
    set_all(1, 0);
    load_w(0);
    send_x(3, 4, 0);
    lat = 0;
    while (lat < 50) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.output_valid) break;
    end
    check("first_valid_latency", lat, 4);
    check("pin_model_sum", model_y(1, 3, 4, 0), 7);
    drain();

    // Negative row 0 under each activation mode.
    Wm[0][0] = -1;
    Wm[0][1] = -1;
    build_w();
    load_w(0);
    send_x(3, 4, 1);
    drain();
    send_x(3, 4, 2);
    drain();
    send_x(3, 4, 3);
    drain();
    check("pin_model_relu", model_y(0, 3, 4, 1), 0);
    check("pin_model_leaky", model_y(0, 3, 4, 2), -1);
    check("pin_model_mode3", model_y(0, 3, 4, 3), -7);
    Bm[0] = 10;
    build_w();
    load_w(0);
    send_x(3, 4, 1);
    drain();
    check("pin_model_bias", model_y(0, 3, 4, 1), 3);

    // Saturation at both rails.
    set_all(127, 0);
    load_w(0);
    send_x(127, 127, 0);
    drain();
    check("pin_model_sat_hi", model_y(2, 127, 127, 0), 127);
    set_all(-128, 0);
    load_w(0);
    send_x(127, 127, 0);
    drain();
    check("pin_model_sat_lo", model_y(3, 127, 127, 0), -128);

    // Backpressure: hold the first beat for 10 cycles.
    set_all(1, 0);
    load_w(0);
    bus.output_ready = 1'b0;
    send_x(3, 4, 0);
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.output_valid) ok = 1'b1;
    end
    check("stall_valid_seen", int'(ok), 1);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      d0 = int'(bus.output_data);
      check("stall_data", d0, 7);
      check("stall_valid", int'(bus.output_valid), 1);
      check("stall_input_ready", int'(bus.input_ready), 0);
      check("stall_w_ready", int'(bus.w_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.output_ready = 1'b1;
    drain();

    // Reset during MAC of group 1: vector aborted, weights retained.
    send_x(3, 4, 0);
    seen = 1'b0;
    ok   = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (bus.output_valid) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
    check("group1_mac_reached", int'(ok), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_output_valid", int'(bus.output_valid), 0);
    check("abort_output_data", int'(bus.output_data), 0);
    check("abort_input_ready", int'(bus.input_ready), 0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_valid_held", int'(bus.output_valid), 0);
    rst_n = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 4 && !ok; t++) begin
      @(negedge clk);
      if (bus.input_ready) ok = 1'b1;
    end
    check("ready_after_abort", int'(ok), 1);
    @(posedge clk);
    #1;
    send_x(3, 4, 0);
    drain();

    // Weight beat wins a simultaneous offer; then back-to-back vectors.
    set_all(1, 0);
    bus.input_valid = 1'b1;
    bus.input_data  = 8'(1);
    bus.act_mode    = 2'd0;
    bus.w_valid     = 1'b1;
    bus.w_data      = 8'(wflat[0]);
    @(negedge clk);
    check("tie_w_ready", int'(bus.w_ready), 1);
    check("tie_input_ready", int'(bus.input_ready), 0);
    @(posedge clk);
    #1;
    load_w(1);
    send_x(1, 1, 0);
    send_x(2, 2, 0);
    check("pin_model_b2b", model_y(0, 2, 2, 0), 4);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/fc_layer_stream.md
Name: fc_layer_stream

Overview:
Parametrised, weight-loadable fully-connected layer core. It computes y = act(W·x + b) for M outputs from N streamed inputs, using P parallel MAC lanes, so M/P output groups are evaluated serially. Weights and biases are loaded at runtime through a dedicated stream. Activation is runtime-selectable (none/ReLU/leaky), and every result is saturated to T bits. It is the reusable successor to the fixed-ROM, ReLU-only FC layer, and sits between stream stages of a generated network.

Parameters:
M, 16, number of outputs; M % P == 0 is required (elaboration error otherwise)
N, 8, number of inputs per vector
T, 16, signed data, weight and bias width
P, 8, number of parallel MAC lanes

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
input_valid  in  1  x beat valid
input_ready  out  1  x beat accepted when input_valid && input_ready
input_data  in  T  signed x element; elements arrive in order n=0..N-1
w_valid  in  1  weight/bias beat valid
w_ready  out  1  weight/bias beat accepted when w_valid && w_ready
w_data  in  T  signed weight or bias word
act_mode  in  2  activation select: 0 none, 1 ReLU, 2 leaky, 3 treated as none
output_valid  out  1  y beat valid
output_ready  in  1  downstream accepts y beat
output_data  out  T  signed y element; elements leave in order m=0..M-1

Behaviour:
- Reset (asserted low, async): state=LOAD_X, all counters 0, output_valid=0, output_data=0, input_ready=0, w_ready=0. Both ready outputs may rise in the first cycle after reset deasserts. Weight and bias storage is not reset; its contents persist across reset.
- States:
  - LOAD_X: accept x beats.
  - MAC: per-group multiply-accumulate.
  - FIN: bias, activation, saturation.
  - OUT: drain results.
- LOAD_X:
  - w_ready = (xcnt==0). input_ready = !(w_valid && xcnt==0); weight beats win any simultaneous offer.
  - Weight stream order: M*N weights row-major (index m*N+n), then M biases (m=0..M-1).
  - Weight m*N+n is stored in lane m%P at address (m/P)*N+n.
  - The weight counter wraps to 0 after M*N+M beats. A partial weight load is legal; a new load resumes at the current counter.
  - act_mode is sampled on the x beat with xcnt==0 and held for the whole vector.
  - After the N-th x beat: xcnt=0, group g=0, go to MAC.
- MAC:
  - Runs N+1 cycles: N registered weight reads plus 1 pipeline stage. The accumulator clears on entry.
  - Accumulator width ACC_W = 2T + clog2(N) + 1, signed. Products are full 2T-bit.
  - Then go to FIN.
- FIN (1 cycle):
  - Add the sign-extended bias at integer scale.
  - Activation: ReLU gives max(0,a); leaky gives a>>>3 (arithmetic) when a<0, else a.
  - Saturate to [-2^(T-1), 2^(T-1)-1].
  - Latch the P lane results into the output register bank, then go to OUT.
- Latency: the first output_valid is asserted N+2 cycles after the clock edge that accepted the last x beat.
- OUT:
  - output_valid=1, output_data = lane k result (k=0..P-1).
  - k advances only on an output_valid && output_ready handshake. output_data is stable while stalled.
  - After the P-th handshake: if g < M/P-1 then g++ and go to MAC; else go to LOAD_X.
  - input_ready can rise in the cycle after the final handshake.
- input_ready=0 and w_ready=0 in MAC, FIN and OUT.
- A reset in the middle of any state aborts the vector. No partial output is emitted after release.

Decomposition:
- fc_pkg holds:
  - enum act_mode_e (ACT_NONE, ACT_RELU, ACT_LEAKY)
  - state enum fc_state_e
  - function acc_width(T,N)
  - function sat(acc, T)
- Sub-module fc_lane_mac, instantiated P times. Each instance contains:
  - weight RAM, (M/P)*N x T, 1-cycle read
  - bias RAM, M/P x T
  - MAC accumulator
  - bias/activation/saturation stage
- The top level holds the FSM, counters, write steering and output mux.

Test Plan:
Config M=4, N=2, T=8, P=2 unless stated.
- All weights 1, biases 0, x=[3,4], mode 0 -> y=[7,7,7,7]; first output_valid exactly 4 cycles after the last x handshake.
- Row0 weights [-1,-1], bias0 0, x=[3,4]: mode 1 -> y0=0; mode 2 -> y0=-1 (-7>>>3); bias0=10 with mode 1 -> y0=3.
- Weights all 127, x=[127,127], biases 0 -> every y=127 (saturated from 32258); weights all -128 -> every y=-128.
- Hold output_ready low for 10 cycles after the first output_valid -> output_data stable, output_valid stays 1, input_ready/w_ready stay 0; release -> remaining 3 beats in order.
- Assert reset during MAC of group 1 -> output_valid=0 immediately; after release input_ready=1; resend x=[3,4] with no reload -> y=[7,7,7,7] (weights retained).
- Drive w_valid and input_valid together at xcnt==0 -> only the weight beat is accepted. Back-to-back vectors [1,1] then [2,2] with all weights 1 -> y=[2,2,2,2] then [4,4,4,4], with no lost or duplicated beats.
